udp_rx_parser: RTL and testbench
================================

UDP_RX_PARSER -- requirements
Module: udp_rx_parser

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DW, 32, payload output width in bits; legal values 8, 16, 32, 64.
- BOARD_MAC, 48'h000a3501fec0, accepted destination MAC. FF:FF:FF:FF:FF:FF is also accepted.
- BOARD_IP, 32'hc0a80002, accepted destination IPv4 address.
- UDP_PORT, 16'h0000, accepted destination port; 0 means any port.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, GMII receive clock.
- clr, in, 1, reset.
- rxd, in, 8, GMII receive data.
- rx_dv, in, 1, GMII data valid.
- m_data, out, DW, payload beat, first byte in the MSBs.
- m_keep, out, DW/8, byte enables, MSB-aligned and contiguous.
- m_valid, out, 1, beat strobe.
- m_last, out, 1, final beat of the frame.
- pc_mac, out, 48, source MAC of the last accepted frame.
- pc_ip, out, 32, source IP of the last accepted frame.
- src_port, out, 16, UDP source port.
- dst_port, out, 16, UDP destination port.
- pay_len, out, 16, payload byte count (UDP length minus 8).
- hdr_valid, out, 1, one-cycle pulse when header fields update.
- pkt_ok, out, 1, one-cycle pulse: frame completed correctly.
- pkt_err, out, 1, one-cycle pulse: frame rejected or truncated.
- err_code, out, 3, cause of the error, valid with pkt_err.

REQ-003 The block SHALL use one clock; reset is asynchronous and active-high. The clock port is named clk and the reset port is named clr.

Function
REQ-004 The state machine SHALL have these states: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DROP, WAIT_IDLE. Only bytes with rx_dv=1 are consumed.

REQ-005 IDLE SHALL go to PREAMBLE on rxd=0x55 with rx_dv=1. PREAMBLE SHALL accept 1 to 7 bytes of 0x55, then 0xD5 moves it to ETH_HDR. Any other byte, an 8th 0x55, or rx_dv=0 SHALL return it to IDLE silently.

REQ-006 ETH_HDR SHALL consume 14 bytes. Errors: destination MAC not equal to BOARD_MAC and not broadcast gives err 1; EtherType not 0x0800 gives err 2.

REQ-007 IP_HDR SHALL consume 20 bytes. Errors: byte0 not 0x45 gives err 3; protocol not 0x11 gives err 4; destination IP not equal to BOARD_IP gives err 5.

REQ-008 UDP_HDR SHALL consume 8 bytes. Errors: UDP_PORT is nonzero and does not match the destination port gives err 6; UDP length less than 8 gives err 7.

REQ-009 Each check SHALL be evaluated on the clock its last field byte is sampled. On failure the block SHALL go to DROP, pulse pkt_err with err_code on the next clock, and then wait in WAIT_IDLE until rx_dv=0.

REQ-010 When UDP_HDR passes, the block SHALL load pc_mac, pc_ip, src_port, dst_port and pay_len together and pulse hdr_valid one clock after the final UDP header byte. The fields SHALL hold until the next accepted frame.

REQ-011 PAYLOAD SHALL pack bytes big-endian. A beat is emitted when DW/8 bytes are collected or when the byte that completes pay_len arrives. m_valid SHALL assert one clock after that byte is sampled and last exactly one cycle.

REQ-012 m_keep SHALL be all ones except on a partial last beat, where it marks the upper N byte lanes. Unused lanes of m_data SHALL be zero.

REQ-013 m_last and pkt_ok SHALL assert in the same cycle as the final beat.

REQ-014 When pay_len is 0, no beat SHALL be emitted and pkt_ok SHALL pulse in the hdr_valid cycle.

REQ-015 If rx_dv drops in the header states, the block SHALL pulse pkt_err with err 7. If rx_dv drops in PAYLOAD, the block SHALL flush the partial beat with m_last=1 and pkt_err=1 with err 7 (pkt_ok=0). If no bytes are pending, it SHALL instead emit m_valid=0 and pkt_err only.

REQ-016 Bytes after the payload (padding and FCS) SHALL be ignored in WAIT_IDLE. A new preamble SHALL be recognised only after at least one cycle of rx_dv=0.

REQ-017 The internal byte counter SHALL be 16 bits and saturating. No data SHALL depend on wrap-around.

Reset
REQ-018 While clr=1, the block SHALL immediately force the state to IDLE and clear all counters. m_valid, m_last, hdr_valid, pkt_ok and pkt_err SHALL be 0. m_data, m_keep, err_code and all header fields SHALL be 0.

REQ-019 When clr asserts mid-frame, the block SHALL discard the frame with no pulse. After clr releases, it SHALL resynchronise on the next preamble.

Structure
REQ-020 The shared package udp_rx_pkg SHALL hold:
- the state enum;
- the err_code constants (1 to 7);
- SFD=0xD5, ETH_TYPE_IPV4=0x0800, IP_PROTO_UDP=0x11 and the header byte counts 14/20/8.

REQ-021 The byte-to-beat packer SHALL be one sub-module, udp_rx_packer (parameter DW; inputs byte, byte_valid, last, flush; outputs data, keep, valid, last).

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- 7x55/D5, matching MAC/IP, port 5000, UDP length 16, payload 01..08, DW=32 -> two beats 01020304 and 05060708, keep=F; m_last and pkt_ok on beat 2; pay_len=8.
- Payload of 5 bytes with DW=32 -> beat 2 is 05000000, keep=8, m_last=1.
- Destination IP 192.168.0.9 -> no m_valid; pkt_err with err_code=5; the next valid frame (after rx_dv=0) is received correctly.
- rx_dv drops after 6 payload bytes of a 10-byte payload -> beat 2 is 05060000, keep=C, m_last=1, pkt_err with err_code=7.
- UDP length 8 -> hdr_valid and pkt_ok in the same cycle, no beat. UDP_PORT=1234 with destination port 5000 -> err_code=6.
- clr pulsed in the middle of an IP header -> all outputs 0, no pulses; the following frame is received correctly.

Source files
------------

// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive parser.
// Holds the parser state encoding, the err_code values reported with
// pkt_err, and the protocol constants and header lengths used when
// walking an Ethernet/IPv4/UDP frame byte by byte.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    DROP,
    WAIT_IDLE
  } state_t;

  localparam logic [2:0] ERR_DST_MAC  = 3'd1;
  localparam logic [2:0] ERR_ETH_TYPE = 3'd2;
  localparam logic [2:0] ERR_IP_VER   = 3'd3;
  localparam logic [2:0] ERR_IP_PROTO = 3'd4;
  localparam logic [2:0] ERR_DST_IP   = 3'd5;
  localparam logic [2:0] ERR_DST_PORT = 3'd6;
  localparam logic [2:0] ERR_LEN      = 3'd7;

  localparam logic [7:0]  PRE_BYTE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

  localparam logic [15:0] ETH_HDR_LEN = 16'd14;
  localparam logic [15:0] IP_HDR_LEN  = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;
  localparam logic [15:0] MAX_PRE     = 16'd7;

endpackage

// File: rtl/udp_rx_packer.sv
// Byte-to-beat packer for the UDP payload.
// Collects bytes big-endian (first byte in the MSBs) and emits a beat
// when DW/8 bytes are held or the frame's last byte arrives. A flush
// emits any partially filled beat with last=1; with nothing pending a
// flush emits nothing.
//   clk, clr     : clock, asynchronous active-high reset
//   byte_data    : incoming payload byte
//   byte_valid   : byte_data is a payload byte this cycle
//   byte_last    : byte_data completes the payload
//   flush        : abandon the frame, push out what is pending
//   data, keep   : beat and MSB-aligned byte enables
//   valid, last  : one-cycle beat strobe, final beat of frame
module udp_rx_packer #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [7:0]      byte_data,
  input  logic            byte_valid,
  input  logic            byte_last,
  input  logic            flush,
  output logic [DW-1:0]   data,
  output logic [DW/8-1:0] keep,
  output logic            valid,
  output logic            last
);

  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB) + 1;

  logic [DW-1:0] acc_p0;
  logic [CW-1:0] n_p0;
  logic [DW-1:0] lane;
  logic [DW-1:0] acc_nxt;
  logic [CW-1:0] n_nxt;

  // Upper n byte lanes enabled.
  function automatic logic [NB-1:0] keep_mask(input logic [CW-1:0] n);
    return ~({NB{1'b1}} >> n);
  endfunction

  always_comb begin
    lane            = '0;
    lane[DW-1 -: 8] = byte_data;
    acc_nxt         = acc_p0 | (lane >> {n_p0, 3'b000});
    n_nxt           = n_p0 + 1'b1;
  end

  // Stage boundary: accumulator -> registered beat
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc_p0 <= '0;
      n_p0   <= '0;
      data   <= '0;
      keep   <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
    end else begin
      valid <= 1'b0;
      last  <= 1'b0;
      if (byte_valid) begin
        if (n_nxt == CW'(NB) || byte_last) begin
          data   <= acc_nxt;
          keep   <= keep_mask(n_nxt);
          valid  <= 1'b1;
          last   <= byte_last;
          acc_p0 <= '0;
          n_p0   <= '0;
        end else begin
          acc_p0 <= acc_nxt;
          n_p0   <= n_nxt;
        end
      end else if (flush && n_p0 != '0) begin
        data   <= acc_p0;
        keep   <= keep_mask(n_p0);
        valid  <= 1'b1;
        last   <= 1'b1;
        acc_p0 <= '0;
        n_p0   <= '0;
      end
    end
  end

endmodule

// File: rtl/udp_rx_parser.sv
// GMII receive parser for Ethernet/IPv4/UDP frames addressed to this board.
// Walks preamble, Ethernet, IPv4 and UDP headers one byte per rx_dv cycle,
// filters on destination MAC/IP/port, publishes the sender's header fields
// and streams the UDP payload out as DW-bit beats.
//   clk, clr            : GMII rx clock, asynchronous active-high reset
//   rxd, rx_dv          : GMII receive byte and data valid
//   m_data/m_keep       : payload beat, MSB-first, MSB-aligned enables
//   m_valid/m_last      : beat strobe, final beat of frame
//   pc_mac, pc_ip       : source MAC/IP of the last accepted frame
//   src_port, dst_port  : UDP ports of the last accepted frame
//   pay_len             : UDP payload length in bytes
//   hdr_valid           : header fields just updated
//   pkt_ok, pkt_err     : frame completed / rejected or truncated
//   err_code            : cause reported alongside pkt_err
module udp_rx_parser
  import udp_rx_pkg::*;
#(
  parameter int          DW        = 32,
  parameter logic [47:0] BOARD_MAC = 48'h000a3501fec0,
  parameter logic [31:0] BOARD_IP  = 32'hc0a80002,
  parameter logic [15:0] UDP_PORT  = 16'h0000
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [7:0]      rxd,
  input  logic            rx_dv,
  output logic [DW-1:0]   m_data,
  output logic [DW/8-1:0] m_keep,
  output logic            m_valid,
  output logic            m_last,
  output logic [47:0]     pc_mac,
  output logic [31:0]     pc_ip,
  output logic [15:0]     src_port,
  output logic [15:0]     dst_port,
  output logic [15:0]     pay_len,
  output logic            hdr_valid,
  output logic            pkt_ok,
  output logic            pkt_err,
  output logic [2:0]      err_code
);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [47:0] sh;
  logic [47:0] sh_next;
  logic [47:0] smac_q;
  logic [31:0] sip_q;
  logic [15:0] sport_q;
  logic [15:0] dport_q;
  logic [15:0] plen_q;
  logic        fail;
  logic [2:0]  fail_code;
  logic        pk_valid;
  logic        pk_last;
  logic        pk_flush;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // sh_next always holds the most recent six bytes including the current one,
  // so every multi-byte field is complete on the cycle its last byte arrives.
  assign cnt_inc  = sat_inc16(cnt);
  assign sh_next  = {sh[39:0], rxd};
  assign pk_valid = (state == PAYLOAD) && rx_dv;
  assign pk_last  = pk_valid && (cnt_inc == plen_q);
  assign pk_flush = (state == PAYLOAD) && !rx_dv;

  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_LEN;
    if (state inside {ETH_HDR, IP_HDR, UDP_HDR}) begin
      if (!rx_dv) begin
        fail = 1'b1;
      end else begin
        case (state)
          ETH_HDR: begin
            if (cnt == 16'd5 && sh_next != BOARD_MAC && sh_next != MAC_BCAST) begin
              fail = 1'b1; fail_code = ERR_DST_MAC;
            end
            if (cnt == ETH_HDR_LEN - 16'd1 && sh_next[15:0] != ETH_TYPE_IPV4) begin
              fail = 1'b1; fail_code = ERR_ETH_TYPE;
            end
          end
          IP_HDR: begin
            if (cnt == 16'd0 && rxd != IP_VER_IHL) begin
              fail = 1'b1; fail_code = ERR_IP_VER;
            end
            if (cnt == 16'd9 && rxd != IP_PROTO_UDP) begin
              fail = 1'b1; fail_code = ERR_IP_PROTO;
            end
            if (cnt == IP_HDR_LEN - 16'd1 && sh_next[31:0] != BOARD_IP) begin
              fail = 1'b1; fail_code = ERR_DST_IP;
            end
          end
          UDP_HDR: begin
            if (cnt == 16'd3 && UDP_PORT != 16'd0 && sh_next[15:0] != UDP_PORT) begin
              fail = 1'b1; fail_code = ERR_DST_PORT;
            end
            if (cnt == 16'd5 && sh_next[15:0] < UDP_HDR_LEN) begin
              fail = 1'b1; fail_code = ERR_LEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  udp_rx_packer #(.DW(DW)) u_packer (
    .clk        (clk),
    .clr        (clr),
    .byte_data  (rxd),
    .byte_valid (pk_valid),
    .byte_last  (pk_last),
    .flush      (pk_flush),
    .data       (m_data),
    .keep       (m_keep),
    .valid      (m_valid),
    .last       (m_last)
  );

  // Stage boundary: sampled GMII byte -> registered state and status
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      smac_q    <= '0;
      sip_q     <= '0;
      sport_q   <= '0;
      dport_q   <= '0;
      plen_q    <= '0;
      pc_mac    <= '0;
      pc_ip     <= '0;
      src_port  <= '0;
      dst_port  <= '0;
      pay_len   <= '0;
      hdr_valid <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      hdr_valid <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      if (rx_dv) sh <= sh_next;

      if (fail) begin
        pkt_err  <= 1'b1;
        err_code <= fail_code;
        cnt      <= '0;
        state    <= rx_dv ? DROP : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_dv) begin
              // A frame joined mid-way is skipped until the line goes idle.
              if (rxd == PRE_BYTE) begin
                state <= PREAMBLE;
                cnt   <= 16'd1;
              end else begin
                state <= WAIT_IDLE;
              end
            end
          end
          PREAMBLE: begin
            if (!rx_dv) begin
              state <= IDLE;
            end else if (rxd == SFD) begin
              state <= ETH_HDR;
              cnt   <= '0;
            end else if (rxd == PRE_BYTE && cnt < MAX_PRE) begin
              cnt <= cnt_inc;
            end else begin
              state <= IDLE;
            end
          end
          ETH_HDR: begin
            cnt <= cnt_inc;
            if (cnt == 16'd11) smac_q <= sh_next;
            if (cnt == ETH_HDR_LEN - 16'd1) begin
              state <= IP_HDR;
              cnt   <= '0;
            end
          end
          IP_HDR: begin
            cnt <= cnt_inc;
            if (cnt == 16'd15) sip_q <= sh_next[31:0];
            if (cnt == IP_HDR_LEN - 16'd1) begin
              state <= UDP_HDR;
              cnt   <= '0;
            end
          end
          UDP_HDR: begin
            cnt <= cnt_inc;
            if (cnt == 16'd1) sport_q <= sh_next[15:0];
            if (cnt == 16'd3) dport_q <= sh_next[15:0];
            if (cnt == 16'd5) plen_q  <= sh_next[15:0] - UDP_HDR_LEN;
            if (cnt == UDP_HDR_LEN - 16'd1) begin
              pc_mac    <= smac_q;
              pc_ip     <= sip_q;
              src_port  <= sport_q;
              dst_port  <= dport_q;
              pay_len   <= plen_q;
              hdr_valid <= 1'b1;
              cnt       <= '0;
              if (plen_q == 16'd0) begin
                pkt_ok <= 1'b1;
                state  <= WAIT_IDLE;
              end else begin
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (!rx_dv) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == plen_q) begin
                pkt_ok <= 1'b1;
                state  <= WAIT_IDLE;
              end
            end
          end
          DROP:      state <= rx_dv ? WAIT_IDLE : IDLE;
          WAIT_IDLE: if (!rx_dv) state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: each directed frame pushes its
// hand-derived output events; monitors pop and compare on every cycle in
// which the parser strobes something.
module tb_udp_rx_parser;

  localparam logic [47:0] MAC_B   = 48'h000a3501fec0;
  localparam logic [31:0] IP_B    = 32'hc0a80002;
  localparam logic [47:0] SRC_MAC = 48'h021122334455;
  localparam logic [31:0] SRC_IP  = 32'hc0a80001;
  localparam logic [15:0] SPORT   = 16'h1F90;
  localparam logic [15:0] DPORT   = 16'd5000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic        sel_p = 1'b0;
  logic        dv_a, dv_b;

  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, hdr_valid, pkt_ok, pkt_err;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;
  logic [15:0] src_port, dst_port, pay_len;
  logic [2:0]  err_code;

  logic [31:0] p_m_data;
  logic [3:0]  p_m_keep;
  logic        p_m_valid, p_m_last, p_hdr_valid, p_pkt_ok, p_pkt_err;
  logic [47:0] p_pc_mac;
  logic [31:0] p_pc_ip;
  logic [15:0] p_src_port, p_dst_port, p_pay_len;
  logic [2:0]  p_err_code;

  assign dv_a = rx_dv & ~sel_p;
  assign dv_b = rx_dv & sel_p;

  always #4 clk = ~clk;

  udp_rx_parser #(.DW(32), .BOARD_MAC(MAC_B), .BOARD_IP(IP_B), .UDP_PORT(16'h0000)) dut (
    .clk(clk), .clr(clr), .rxd(rxd), .rx_dv(dv_a),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last),
    .pc_mac(pc_mac), .pc_ip(pc_ip), .src_port(src_port), .dst_port(dst_port),
    .pay_len(pay_len), .hdr_valid(hdr_valid), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code)
  );

  udp_rx_parser #(.DW(32), .BOARD_MAC(MAC_B), .BOARD_IP(IP_B), .UDP_PORT(16'd1234)) dut_p (
    .clk(clk), .clr(clr), .rxd(rxd), .rx_dv(dv_b),
    .m_data(p_m_data), .m_keep(p_m_keep), .m_valid(p_m_valid), .m_last(p_m_last),
    .pc_mac(p_pc_mac), .pc_ip(p_pc_ip), .src_port(p_src_port), .dst_port(p_dst_port),
    .pay_len(p_pay_len), .hdr_valid(p_hdr_valid), .pkt_ok(p_pkt_ok), .pkt_err(p_pkt_err),
    .err_code(p_err_code)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        h;
    logic [15:0] pl;
    logic        ok;
    logic        er;
    logic [2:0]  ec;
  } ev_t;

  ev_t q[$];
  ev_t q2[$];
  logic [7:0] fb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".m_valid"},   m_valid,   0);
    chk({tag, ".m_last"},    m_last,    0);
    chk({tag, ".hdr_valid"}, hdr_valid, 0);
    chk({tag, ".pkt_ok"},    pkt_ok,    0);
    chk({tag, ".pkt_err"},   pkt_err,   0);
    chk({tag, ".m_data"},    m_data,    0);
    chk({tag, ".m_keep"},    m_keep,    0);
    chk({tag, ".err_code"},  err_code,  0);
    chk({tag, ".pc_mac"},    pc_mac,    0);
    chk({tag, ".pc_ip"},     pc_ip,     0);
    chk({tag, ".src_port"},  src_port,  0);
    chk({tag, ".dst_port"},  dst_port,  0);
    chk({tag, ".pay_len"},   pay_len,   0);
  endtask

  task automatic exp_hdr(input logic [15:0] pl, input logic ok);
    q.push_back('{v:1'b0, d:32'h0, k:4'h0, l:1'b0, h:1'b1, pl:pl, ok:ok, er:1'b0, ec:3'd0});
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                          input logic ok, input logic er, input logic [2:0] ec);
    q.push_back('{v:1'b1, d:d, k:k, l:l, h:1'b0, pl:16'h0, ok:ok, er:er, ec:ec});
  endtask

  task automatic exp_err(input logic [2:0] ec);
    q.push_back('{v:1'b0, d:32'h0, k:4'h0, l:1'b0, h:1'b0, pl:16'h0, ok:1'b0, er:1'b1, ec:ec});
  endtask

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
  endtask

  // Builds and drives one frame; clr_at >= 0 pulses clr on that byte index.
  task automatic send_frame(input logic [31:0] dip, input logic [15:0] ulen,
                            input int npay, input int extra, input int clr_at);
    fb.delete();
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    push_be(MAC_B, 6);
    push_be(SRC_MAC, 6);
    push_be(16'h0800, 2);
    push_be(16'h4500, 2);
    push_be(20 + ulen, 2);
    push_be(32'h0, 4);
    push_be(16'h4011, 2);
    push_be(16'h0000, 2);
    push_be(SRC_IP, 4);
    push_be(dip, 4);
    push_be(SPORT, 2);
    push_be(DPORT, 2);
    push_be(ulen, 2);
    push_be(16'h0000, 2);
    for (int i = 1; i <= npay; i++) fb.push_back(8'(i));
    for (int i = 0; i < extra; i++) fb.push_back(8'hEE);
    for (int i = 0; i < fb.size(); i++) begin
      @(negedge clk);
      rxd   = fb[i];
      rx_dv = 1'b1;
      if (i == clr_at) begin
        clr = 1'b1;
        #1 chk_zero("clr_mid");
      end else begin
        clr = 1'b0;
      end
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rxd   = 8'h00;
    clr   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (m_valid || hdr_valid || pkt_ok || pkt_err) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got v=%0b h=%0b ok=%0b err=%0b expected none at %0t",
                 m_valid, hdr_valid, pkt_ok, pkt_err, $time);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("m_valid", m_valid, e.v);
        if (e.v) begin
          chk("m_data", m_data, e.d);
          chk("m_keep", m_keep, e.k);
          chk("m_last", m_last, e.l);
        end
        chk("hdr_valid", hdr_valid, e.h);
        if (e.h) begin
          chk("pay_len",  pay_len,  e.pl);
          chk("src_port", src_port, SPORT);
          chk("dst_port", dst_port, DPORT);
          chk("pc_mac",   pc_mac,   SRC_MAC);
          chk("pc_ip",    pc_ip,    SRC_IP);
        end
        chk("pkt_ok",  pkt_ok,  e.ok);
        chk("pkt_err", pkt_err, e.er);
        if (e.er) chk("err_code", err_code, e.ec);
      end
    end
  end

  always @(negedge clk) begin
    if (p_m_valid || p_hdr_valid || p_pkt_ok || p_pkt_err) begin
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event_p: got v=%0b h=%0b ok=%0b err=%0b expected none at %0t",
                 p_m_valid, p_hdr_valid, p_pkt_ok, p_pkt_err, $time);
      end else begin
        ev_t e;
        e = q2.pop_front();
        chk("p.m_valid",   p_m_valid,   e.v);
        chk("p.hdr_valid", p_hdr_valid, e.h);
        chk("p.pkt_ok",    p_pkt_ok,    e.ok);
        chk("p.pkt_err",   p_pkt_err,   e.er);
        if (e.er) chk("p.err_code", p_err_code, e.ec);
      end
    end
  end

  initial begin
    clr = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // 8-byte payload, two full beats
    exp_hdr(16'd8, 1'b0);
    exp_beat(32'h01020304, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0);
    exp_beat(32'h05060708, 4'hF, 1'b1, 1'b1, 1'b0, 3'd0);
    send_frame(IP_B, 16'd16, 8, 0, -1);

    // 5-byte payload, partial last beat, trailing FCS ignored
    exp_hdr(16'd5, 1'b0);
    exp_beat(32'h01020304, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0);
    exp_beat(32'h05000000, 4'h8, 1'b1, 1'b1, 1'b0, 3'd0);
    send_frame(IP_B, 16'd13, 5, 4, -1);

    // wrong destination IP, then a good frame
    exp_err(3'd5);
    send_frame(32'hc0a80009, 16'd16, 8, 0, -1);
    exp_hdr(16'd4, 1'b0);
    exp_beat(32'h01020304, 4'hF, 1'b1, 1'b1, 1'b0, 3'd0);
    send_frame(IP_B, 16'd12, 4, 0, -1);

    // rx_dv drops after 6 of 10 payload bytes
    exp_hdr(16'd10, 1'b0);
    exp_beat(32'h01020304, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0);
    exp_beat(32'h05060000, 4'hC, 1'b1, 1'b0, 1'b1, 3'd7);
    send_frame(IP_B, 16'd18, 6, 0, -1);

    // empty payload: header and ok together
    exp_hdr(16'd0, 1'b1);
    send_frame(IP_B, 16'd8, 0, 2, -1);

    // port filter 1234 against destination port 5000
    sel_p = 1'b1;
    q2.push_back('{v:1'b0, d:32'h0, k:4'h0, l:1'b0, h:1'b0, pl:16'h0, ok:1'b0, er:1'b1, ec:3'd6});
    send_frame(IP_B, 16'd16, 8, 0, -1);
    sel_p = 1'b0;

    // clr in the middle of the IP header, then a good frame
    send_frame(IP_B, 16'd16, 8, 0, 32);
    exp_hdr(16'd8, 1'b0);
    exp_beat(32'h01020304, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0);
    exp_beat(32'h05060708, 4'hF, 1'b1, 1'b1, 1'b0, 3'd0);
    send_frame(IP_B, 16'd16, 8, 0, -1);

    for (int i = 0; i < 50 && (q.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    chk("events_pending",   q.size(),  0);
    chk("events_pending_p", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
